psr_cond_unit: RTL and testbench

- Consumer end of the ALU flag interface.
- Holds the processor status register (PSR) flags C, L, F, Z, N written by the ALU and by the LPR (load-PSR) path.
- Resolves conditional branch/jump condition codes against those flags.
- Returns a registered taken/not-taken result to the fetch/PC logic through a valid/ready handshake with one-entry holding.

---
 rtl/psr_pkg.sv | 35 +++
 rtl/cond_eval.sv | 42 ++++
 rtl/psr_cond_unit.sv | 80 ++++++++
 tb/tb_psr_cond_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// Shared definitions for the PSR flag interface: flag bit positions, CR16 condition
// codes and the result-register state encoding.
package psr_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_HI = 4'b0100,
        COND_LS = 4'b0101,
        COND_GT = 4'b0110,
        COND_LE = 4'b0111,
        COND_FS = 4'b1000,
        COND_FC = 4'b1001,
        COND_LO = 4'b1010,
        COND_HS = 4'b1011,
        COND_LT = 4'b1100,
        COND_GE = 4'b1101,
        COND_UC = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational CR16 condition resolver: maps a condition code and the
// {N,Z,F,L,C} flags to branch taken / not taken. Shared with the Jcond path.
module cond_eval
    import psr_pkg::*;
(
    input  logic [3:0] cond_code,
    input  logic [4:0] flags,
    output logic       taken
);

    logic c, l, f, z, n;

    assign c = flags[FLAG_C];
    assign l = flags[FLAG_L];
    assign f = flags[FLAG_F];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond_code))
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_HI: taken = l;
            COND_LS: taken = !l;
            COND_GT: taken = n;
            COND_LE: taken = !n;
            COND_FS: taken = f;
            COND_FC: taken = !f;
            COND_LO: taken = !l && !z;
            COND_HS: taken = l || z;
            COND_LT: taken = !n && !z;
            COND_GE: taken = n || z;
            COND_UC: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_cond_unit.sv
// PSR flag register plus condition resolution with a one-entry registered
// result toward fetch/PC, handed off via valid/ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no result held; cond_ready = 1, a request loads the register
// ST_FULL  | result held in res_taken; cond_ready follows res_ready
module psr_cond_unit
    import psr_pkg::*;
#(
    parameter logic [4:0] PSR_RESET = 5'b00000,
    parameter bit         BYPASS    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] flag_we,
    input  logic [4:0] flag_in,
    input  logic       psr_we,
    input  logic [4:0] psr_wdata,
    output logic [4:0] psr_rdata,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       res_valid,
    output logic       res_taken,
    input  logic       res_ready
);

    logic [4:0] psr_q;
    logic [4:0] psr_d;
    logic [4:0] flags_eff;
    logic       taken_d;
    logic       taken_q;
    res_state_e state_q;

    // LPR overrides any ALU flag write landing in the same cycle.
    assign psr_d = psr_we ? psr_wdata : ((psr_q & ~flag_we) | (flag_in & flag_we));

    assign flags_eff = BYPASS ? psr_d : psr_q;

    cond_eval u_cond_eval (
        .cond_code (cond_code),
        .flags     (flags_eff),
        .taken     (taken_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_q   <= PSR_RESET;
            state_q <= ST_EMPTY;
            taken_q <= 1'b0;
        end else begin
            psr_q <= psr_d;
            case (state_q)
                ST_EMPTY: begin
                    if (cond_valid) begin
                        taken_q <= taken_d;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (res_ready) begin
                        if (cond_valid) begin
                            taken_q <= taken_d;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign psr_rdata  = psr_q;
    assign res_valid  = (state_q == ST_FULL);
    assign res_taken  = taken_q;
    assign cond_ready = (state_q == ST_EMPTY) || res_ready;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Bench for psr_cond_unit: a forwarding and a non-forwarding instance share stimulus;
// a table, hand sequences and random traffic are scored against a flag/handshake model.
module tb_psr_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] flag_we, flag_in, psr_wdata;
    logic       psr_we, cond_valid, res_ready;
    logic [3:0] cond_code;

    logic [4:0] psr_rdata, psr_rdata_nb;
    logic       cond_ready, cond_ready_nb;
    logic       res_valid, res_valid_nb;
    logic       res_taken, res_taken_nb;

    int total = 0;
    int bad   = 0;

    logic [4:0] m_psr;
    logic       m_v, m_t1, m_t0;

    always #5 clk = ~clk;

    psr_cond_unit #(.PSR_RESET(5'b00000), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(rst), .flag_we(flag_we), .flag_in(flag_in),
        .psr_we(psr_we), .psr_wdata(psr_wdata), .psr_rdata(psr_rdata),
        .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready)
    );

    psr_cond_unit #(.PSR_RESET(5'b00000), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(rst), .flag_we(flag_we), .flag_in(flag_in),
        .psr_we(psr_we), .psr_wdata(psr_wdata), .psr_rdata(psr_rdata_nb),
        .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready_nb),
        .res_valid(res_valid_nb), .res_taken(res_taken_nb), .res_ready(res_ready)
    );

    typedef struct {
        logic [4:0] fwe;
        logic [4:0] fin;
        logic       pwe;
        logic [4:0] pwd;
        logic [3:0] code;
        logic [4:0] e_psr;
        logic       e_t1;
        logic       e_t0;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition truth written directly from the named flags.
    function automatic logic eval(input logic [3:0] code, input logic [4:0] fl);
        logic c, l, f, z, n;
        c = fl[0]; l = fl[1]; f = fl[2]; z = fl[3]; n = fl[4];
        case (code)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return f;
            4'd9:  return !f;
            4'd10: return !(l || z);
            4'd11: return l || z;
            4'd12: return !(n || z);
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_psr = 5'b00000;
        m_v   = 1'b0;
        m_t1  = 1'b0;
        m_t0  = 1'b0;
    endtask

    // One clock: check ready before the edge, advance the model, check after it.
    task automatic tick();
        logic [4:0] nxt;
        logic       e_ready;
        #1;
        e_ready = !m_v || res_ready;
        chk("cond_ready", {7'b0, cond_ready}, {7'b0, e_ready});
        chk("cond_ready_nb", {7'b0, cond_ready_nb}, {7'b0, e_ready});
        nxt = m_psr;
        if (psr_we) nxt = psr_wdata;
        else
            for (int i = 0; i < 5; i++)
                if (flag_we[i]) nxt[i] = flag_in[i];
        if (cond_valid && e_ready) begin
            m_v  = 1'b1;
            m_t1 = eval(cond_code, nxt);
            m_t0 = eval(cond_code, m_psr);
        end else if (m_v && res_ready) begin
            m_v = 1'b0;
        end
        m_psr = nxt;
        @(posedge clk);
        #1;
        chk("psr_rdata", {3'b0, psr_rdata}, {3'b0, m_psr});
        chk("psr_rdata_nb", {3'b0, psr_rdata_nb}, {3'b0, m_psr});
        chk("res_valid", {7'b0, res_valid}, {7'b0, m_v});
        chk("res_valid_nb", {7'b0, res_valid_nb}, {7'b0, m_v});
        chk("res_taken", {7'b0, res_taken}, {7'b0, m_t1});
        chk("res_taken_nb", {7'b0, res_taken_nb}, {7'b0, m_t0});
    endtask

    task automatic idle_inputs();
        flag_we = 5'b0; flag_in = 5'b0; psr_we = 1'b0; psr_wdata = 5'b0;
        cond_valid = 1'b0; cond_code = 4'b0; res_ready = 1'b1;
    endtask

    initial begin
        //            fwe       fin       pwe  pwd       code     e_psr     t1    t0
        tbl[0]  = '{5'b01000, 5'b11111, 1'b0, 5'b00000, 4'b0000, 5'b01000, 1'b1, 1'b0};
        tbl[1]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b0001, 5'b01000, 1'b0, 1'b0};
        tbl[2]  = '{5'b11111, 5'b00000, 1'b1, 5'b00001, 4'b0010, 5'b00001, 1'b1, 1'b0};
        tbl[3]  = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 4'b1010, 5'b00000, 1'b1, 1'b1};
        tbl[4]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b1011, 5'b00000, 1'b0, 1'b0};
        tbl[5]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b1100, 5'b00000, 1'b1, 1'b1};
        tbl[6]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b1101, 5'b00000, 1'b0, 1'b0};
        tbl[7]  = '{5'b01000, 5'b01000, 1'b0, 5'b00000, 4'b1010, 5'b01000, 1'b0, 1'b1};
        tbl[8]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b1011, 5'b01000, 1'b1, 1'b1};
        tbl[9]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b1101, 5'b01000, 1'b1, 1'b1};
        tbl[10] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b1110, 5'b01000, 1'b1, 1'b1};
        tbl[11] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b1111, 5'b01000, 1'b0, 1'b0};
        tbl[12] = '{5'b10000, 5'b10000, 1'b0, 5'b00000, 4'b0110, 5'b11000, 1'b1, 1'b0};
        tbl[13] = '{5'b00110, 5'b00100, 1'b0, 5'b00000, 4'b1000, 5'b11100, 1'b1, 1'b0};
        tbl[14] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b0100, 5'b11100, 1'b0, 1'b0};
        tbl[15] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b0101, 5'b11100, 1'b1, 1'b1};

        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("reset_psr", {3'b0, psr_rdata}, 8'h00);
        chk("reset_valid", {7'b0, res_valid}, 8'h00);
        chk("reset_taken", {7'b0, res_taken}, 8'h00);
        chk("reset_ready", {7'b0, cond_ready}, 8'h01);
        @(posedge clk);
        #1;

        // Table: one accepted request per cycle with flag writes alongside.
        for (int k = 0; k < 16; k++) begin
            flag_we = tbl[k].fwe; flag_in = tbl[k].fin;
            psr_we = tbl[k].pwe; psr_wdata = tbl[k].pwd;
            cond_valid = 1'b1; cond_code = tbl[k].code; res_ready = 1'b1;
            tick();
            chk($sformatf("tbl%0d_psr", k), {3'b0, psr_rdata}, {3'b0, tbl[k].e_psr});
            chk($sformatf("tbl%0d_valid", k), {7'b0, res_valid}, 8'h01);
            chk($sformatf("tbl%0d_taken", k), {7'b0, res_taken}, {7'b0, tbl[k].e_t1});
            chk($sformatf("tbl%0d_taken_nb", k), {7'b0, res_taken_nb}, {7'b0, tbl[k].e_t0});
        end

        // Asynchronous reset between edges while a result is held.
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("async_valid", {7'b0, res_valid}, 8'h00);
        chk("async_valid_nb", {7'b0, res_valid_nb}, 8'h00);
        chk("async_psr", {3'b0, psr_rdata}, 8'h00);
        chk("async_taken", {7'b0, res_taken}, 8'h00);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure: held result ignores Z toggles, release gives next result with no bubble.
        psr_we = 1'b1; psr_wdata = 5'b01000;
        tick();
        psr_we = 1'b0;
        cond_valid = 1'b1; cond_code = 4'b0000; res_ready = 1'b0;
        tick();
        chk("bp_first_taken", {7'b0, res_taken}, 8'h01);
        cond_code = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            flag_we = 5'b01000; flag_in = {1'b0, ~m_psr[3], 3'b000};
            tick();
            chk("bp_hold_taken", {7'b0, res_taken}, 8'h01);
            chk("bp_hold_valid", {7'b0, res_valid}, 8'h01);
            chk("bp_hold_ready", {7'b0, cond_ready}, 8'h00);
        end
        flag_we = 5'b01000; flag_in = {1'b0, ~m_psr[3], 3'b000};
        res_ready = 1'b1;
        tick();
        chk("bp_release_valid", {7'b0, res_valid}, 8'h01);
        chk("bp_release_taken", {7'b0, res_taken}, 8'h00);
        chk("bp_release_taken_nb", {7'b0, res_taken_nb}, 8'h01);
        idle_inputs();
        tick();
        chk("bp_drain_valid", {7'b0, res_valid}, 8'h00);

        // Random traffic; a stalled request is held stable until accepted.
        for (int k = 0; k < 400; k++) begin
            logic stalled;
            stalled = cond_valid && m_v && !res_ready;
            if (!stalled) begin
                cond_valid = ($urandom_range(0, 3) != 0);
                cond_code  = 4'($urandom_range(0, 15));
            end
            flag_we   = 5'($urandom);
            flag_in   = 5'($urandom);
            psr_we    = ($urandom_range(0, 7) == 0);
            psr_wdata = 5'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
